// File: rtl/combinational_circuit_pkg.sv
// Shared definitions for the 4-input truth-table function block.
// Holds the default prime-detector table and the table lookup helper.
// Pure declarations; no state, no flow control.
package combinational_circuit_pkg;

  // Bit i is 1 when i is prime (2, 3, 5, 7, 11, 13).
  localparam logic [15:0] PRIME4_TABLE = 16'h28AC;

  // Looks up the result for a 4-bit index. An X or Z index gives X in simulation.
  function automatic logic ref_eval(input logic [15:0] tbl, input logic [3:0] idx);
    return tbl[idx];
  endfunction

endpackage

// File: rtl/combinational_circuit.sv
// 4-input Boolean function: y = TRUTH_TABLE[{a,b,c,d}], plus a registered copy.
// Latency: y has zero cycles; y_q has one cycle. Async reset clears only y_q.
// No backpressure: the block accepts a new index every cycle.
module combinational_circuit
  import combinational_circuit_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE = PRIME4_TABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic y,
  output logic y_q
);

  logic [3:0] idx;
  logic       y_d;
  logic       y_reg_q;

  assign idx = {a, b, c, d};

  // Table lookup; every index 0..15 is defined, so no latch is possible.
  always_comb begin
    y_d = ref_eval(TRUTH_TABLE, idx);
  end

  assign y = y_d;

  // Registered copy of the function value. Reset takes effect without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_reg_q <= 1'b0;
    end else begin
      y_reg_q <= y_d;
    end
  end

  assign y_q = y_reg_q;

endmodule

// File: tb/tb_combinational_circuit.sv
// Bench for combinational_circuit: table-driven sweep plus hand-written
// sequences for the registered path, async reset and parameter overrides.
module tb_combinational_circuit;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic y_def, yq_def;
  logic y_and, yq_and;
  logic y_or,  yq_or;

  int total;
  int bad;

  combinational_circuit u_def (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .y(y_def), .y_q(yq_def)
  );

  combinational_circuit #(.TRUTH_TABLE(16'h8000)) u_and (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .y(y_and), .y_q(yq_and)
  );

  combinational_circuit #(.TRUTH_TABLE(16'hFFFE)) u_or (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .y(y_or), .y_q(yq_or)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic       exp_def;
    logic       exp_and;
    logic       exp_or;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idx(input logic [4:0] v);
    logic [3:0] t;
    t = v[3:0];
    {a, b, c, d} = t;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // idx, prime, AND, OR -- entry 16 truncates to index 0
    vecs[0]  = '{5'd0,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd1,  1'b0, 1'b0, 1'b1};
    vecs[2]  = '{5'd2,  1'b1, 1'b0, 1'b1};
    vecs[3]  = '{5'd3,  1'b1, 1'b0, 1'b1};
    vecs[4]  = '{5'd4,  1'b0, 1'b0, 1'b1};
    vecs[5]  = '{5'd5,  1'b1, 1'b0, 1'b1};
    vecs[6]  = '{5'd6,  1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd7,  1'b1, 1'b0, 1'b1};
    vecs[8]  = '{5'd8,  1'b0, 1'b0, 1'b1};
    vecs[9]  = '{5'd9,  1'b0, 1'b0, 1'b1};
    vecs[10] = '{5'd10, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{5'd11, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{5'd12, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{5'd13, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{5'd14, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{5'd15, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{5'd16, 1'b0, 1'b0, 1'b0};

    // Reset state
    rst = 1'b1;
    set_idx(5'd2);
    #1;
    chk("reset_yq_def", yq_def, 1'b0);
    chk("reset_yq_and", yq_and, 1'b0);
    chk("reset_yq_or",  yq_or,  1'b0);
    chk("reset_y_live", y_def,  1'b1);

    // Exhaustive combinational sweep, 5 time units per step
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_idx(vecs[i].idx);
      #1;
      chk($sformatf("sweep_def_%0d", vecs[i].idx), y_def, vecs[i].exp_def);
      chk($sformatf("sweep_and_%0d", vecs[i].idx), y_and, vecs[i].exp_and);
      chk($sformatf("sweep_or_%0d",  vecs[i].idx), y_or,  vecs[i].exp_or);
      #4;
    end

    // Registered path: one-cycle latency
    @(negedge clk);
    set_idx(5'd0);
    @(posedge clk); #1;
    chk("reg_idx0", yq_def, 1'b0);
    @(negedge clk);
    set_idx(5'd7);
    #1;
    chk("reg_idx7_before_edge", yq_def, 1'b0);
    chk("reg_idx7_y", y_def, 1'b1);
    @(posedge clk); #1;
    chk("reg_idx7_after_edge", yq_def, 1'b1);
    @(negedge clk);
    set_idx(5'd8);
    #1;
    chk("reg_idx8_before_edge", yq_def, 1'b1);
    @(posedge clk); #1;
    chk("reg_idx8_after_edge", yq_def, 1'b0);

    // Async reset between edges
    @(negedge clk);
    set_idx(5'd13);
    @(posedge clk); #1;
    chk("async_pre_yq", yq_def, 1'b1);
    chk("async_pre_or_yq", yq_or, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_yq_cleared", yq_def, 1'b0);
    chk("async_or_yq_cleared", yq_or, 1'b0);
    chk("async_y_kept", y_def, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("async_release_no_edge", yq_def, 1'b0);
    @(posedge clk); #1;
    chk("async_release_reload", yq_def, 1'b1);

    // Reset held across 4 clocks while sweeping primes
    @(negedge clk);
    rst = 1'b1;
    begin
      logic [4:0] primes [4];
      primes[0] = 5'd2; primes[1] = 5'd3; primes[2] = 5'd5; primes[3] = 5'd7;
      for (int i = 0; i < 4; i++) begin
        set_idx(primes[i]);
        @(posedge clk); #1;
        chk($sformatf("held_yq_%0d", primes[i]), yq_def, 1'b0);
        chk($sformatf("held_y_%0d",  primes[i]), y_def,  1'b1);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("held_release_idx7", yq_def, 1'b1);

    // Toggle a alone between 3 and 11: y stays 1
    for (int i = 0; i < 4; i++) begin
      set_idx((i % 2 == 0) ? 5'd3 : 5'd11);
      #1;
      chk($sformatf("toggle_a_%0d", i), y_def, 1'b1);
      #2;
    end

    // Toggle d between 6 and 7: y goes 0 -> 1
    set_idx(5'd6);
    #1;
    chk("toggle_d_6", y_def, 1'b0);
    set_idx(5'd7);
    #1;
    chk("toggle_d_7", y_def, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
